// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv: EX-stage ALU controller with an iterative RV32M multiply/divide unit.
// The ALU opcode is decoded from ALUOp/Funct3/Funct7. M-extension ops are run by a
// one-bit-per-cycle sequencer that stalls the pipeline until its result is ready.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ALUOp, RType,        instruction class and function fields from the main controller
//   Funct7, Funct3
//   valid_i, flush_i     EX holds a valid instruction / EX is being flushed
//   SrcA, SrcB           rs1 / rs2 operands
//   Operation            4-bit ALU opcode (combinational)
//   md_sel               result mux selects md_result (combinational, M op decoded)
//   md_result, md_done   M-op result and its one-cycle ready pulse (registered)
//   stall_o              hold IF/ID/EX while an M op is in flight (combinational)
module alu_ctrl_muldiv #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          EN_MULDIV  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            ALUOp,
    input  logic                  RType,
    input  logic [6:0]            Funct7,
    input  logic [2:0]            Funct3,
    input  logic                  valid_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic [3:0]            Operation,
    output logic                  md_sel,
    output logic [DATA_WIDTH-1:0] md_result,
    output logic                  md_done,
    output logic                  stall_o
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DW + 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_BNE   = 4'b1001;
    localparam logic [3:0] OP_BLT   = 4'b1010;
    localparam logic [3:0] OP_BGE   = 4'b1011;
    localparam logic [3:0] OP_SLT   = 4'b1100;
    localparam logic [3:0] OP_SLTU  = 4'b1101;
    localparam logic [3:0] OP_PASSB = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic [DW-1:0]   acc;       // product high half / partial remainder
    logic [DW-1:0]   lo;        // multiplier + product low half / dividend + quotient
    logic [DW-1:0]   opb;       // multiplicand / divisor magnitude
    logic            neg_main;  // negate product or quotient
    logic            neg_rem;   // negate remainder
    logic            sel_alt;   // return product high half or remainder

    logic            is_md;

    // M-extension decode
    assign is_md   = EN_MULDIV && (ALUOp == 2'b10) && RType && (Funct7 == 7'b0000001);
    assign md_sel  = is_md;
    assign stall_o = valid_i && is_md && (state != S_DONE) && !flush_i;

    // ALU opcode decode
    always_comb begin
        Operation = OP_ADD;
        case (ALUOp)
            2'b00: Operation = OP_ADD;
            2'b01: begin
                case (Funct3)
                    3'b001:  Operation = OP_BNE;
                    3'b100:  Operation = OP_BLT;
                    3'b101:  Operation = OP_BGE;
                    default: Operation = OP_BEQ;
                endcase
            end
            2'b10: begin
                if (!is_md) begin
                    case (Funct3)
                        3'b000:  Operation = (RType && (Funct7 == 7'b0100000)) ? OP_SUB : OP_ADD;
                        3'b001:  Operation = OP_SLL;
                        3'b010:  Operation = OP_SLT;
                        3'b011:  Operation = OP_SLTU;
                        3'b100:  Operation = OP_XOR;
                        3'b101:  Operation = Funct7[5] ? OP_SRA : OP_SRL;
                        3'b110:  Operation = OP_OR;
                        default: Operation = OP_AND;
                    endcase
                end
            end
            default: Operation = OP_PASSB;
        endcase
    end

    // Operand signedness and magnitudes at start of an M op
    logic          a_sgn, b_sgn, a_neg, b_neg;
    logic [DW-1:0] a_mag, b_mag;
    logic          div_zero, div_ovf;
    logic [DW-1:0] fast_res;

    always_comb begin
        a_sgn    = Funct3[2] ? !Funct3[0] : (Funct3[1:0] != 2'b11);
        b_sgn    = Funct3[2] ? !Funct3[0] : !Funct3[1];
        a_neg    = a_sgn && SrcA[DW-1];
        b_neg    = b_sgn && SrcB[DW-1];
        a_mag    = a_neg ? -SrcA : SrcA;
        b_mag    = b_neg ? -SrcB : SrcB;
        div_zero = (SrcB == '0);
        div_ovf  = !Funct3[0] && (SrcA == {1'b1, {(DW-1){1'b0}}}) && (SrcB == '1);
        // Divide-by-zero: quotient all-ones, remainder = dividend.
        // Signed overflow: quotient = MIN (the dividend itself), remainder = 0.
        if (div_zero) begin
            fast_res = Funct3[1] ? SrcA : '1;
        end else begin
            fast_res = Funct3[1] ? '0 : SrcA;
        end
    end

    // One shift-add or restoring-divide step plus final sign fix
    logic [DW:0]     mul_sum, div_shift, div_trial;
    logic [DW-1:0]   acc_n, lo_n;
    logic [2*DW-1:0] prod, prod_fix;
    logic [DW-1:0]   q_fix, r_fix, step_res;

    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc, lo[DW-1]};
        div_trial = div_shift - {1'b0, opb};
        acc_n     = acc;
        lo_n      = lo;
        if (state == S_MUL) begin
            acc_n = mul_sum[DW:1];
            lo_n  = {mul_sum[0], lo[DW-1:1]};
        end else if (!div_trial[DW]) begin
            acc_n = div_trial[DW-1:0];
            lo_n  = {lo[DW-2:0], 1'b1};
        end else begin
            acc_n = div_shift[DW-1:0];
            lo_n  = {lo[DW-2:0], 1'b0};
        end
        prod     = {acc_n, lo_n};
        prod_fix = neg_main ? -prod : prod;
        q_fix    = neg_main ? -lo_n : lo_n;
        r_fix    = neg_rem ? -acc_n : acc_n;
        if (state == S_MUL) begin
            step_res = sel_alt ? prod_fix[2*DW-1:DW] : prod_fix[DW-1:0];
        end else begin
            step_res = sel_alt ? r_fix : q_fix;
        end
    end

    // Sequencer FSM with registered result and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            counter   <= '0;
            acc       <= '0;
            lo        <= '0;
            opb       <= '0;
            neg_main  <= 1'b0;
            neg_rem   <= 1'b0;
            sel_alt   <= 1'b0;
            md_result <= '0;
            md_done   <= 1'b0;
        end else begin
            md_done <= 1'b0;
            if (flush_i) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (valid_i && is_md) begin
                            if (Funct3[2] && (div_zero || div_ovf)) begin
                                md_result <= fast_res;
                                md_done   <= 1'b1;
                                state     <= S_DONE;
                            end else begin
                                acc      <= '0;
                                lo       <= a_mag;
                                opb      <= b_mag;
                                neg_main <= a_neg ^ b_neg;
                                neg_rem  <= a_neg;
                                sel_alt  <= Funct3[2] ? Funct3[1] : (Funct3[1:0] != 2'b00);
                                counter  <= CW'(DW);
                                state    <= Funct3[2] ? S_DIV : S_MUL;
                            end
                        end
                    end
                    S_MUL, S_DIV: begin
                        acc     <= acc_n;
                        lo      <= lo_n;
                        counter <= counter - CW'(1);
                        if (counter == CW'(1)) begin
                            md_result <= step_res;
                            md_done   <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// tb_alu_ctrl_muldiv: directed self-checking bench for alu_ctrl_muldiv (DATA_WIDTH=32).
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_alu_ctrl_muldiv;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    ALUOp;
    logic          RType;
    logic [6:0]    Funct7;
    logic [2:0]    Funct3;
    logic          valid_i;
    logic          flush_i;
    logic [DW-1:0] SrcA;
    logic [DW-1:0] SrcB;
    logic [3:0]    Operation;
    logic          md_sel;
    logic [DW-1:0] md_result;
    logic          md_done;
    logic          stall_o;

    int checks   = 0;
    int failures = 0;

    alu_ctrl_muldiv #(
        .DATA_WIDTH (DW),
        .EN_MULDIV  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ALUOp     (ALUOp),
        .RType     (RType),
        .Funct7    (Funct7),
        .Funct3    (Funct3),
        .valid_i   (valid_i),
        .flush_i   (flush_i),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .md_sel    (md_sel),
        .md_result (md_result),
        .md_done   (md_done),
        .stall_o   (stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic dec(input string tag, input logic [1:0] op, input logic rt,
                       input logic [6:0] f7, input logic [2:0] f3,
                       input logic [3:0] exp_op, input logic exp_sel);
        ALUOp  = op;
        RType  = rt;
        Funct7 = f7;
        Funct3 = f3;
        #1;
        check({tag, "_op"}, 64'(Operation), 64'(exp_op));
        check({tag, "_sel"}, 64'(md_sel), 64'(exp_sel));
    endtask

    // Issue one M op, scramble operands after start, check latency/stall/result.
    task automatic run_md(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int stall_cnt;
        ALUOp   = 2'b10;
        RType   = 1'b1;
        Funct7  = 7'b0000001;
        Funct3  = f3;
        SrcA    = a;
        SrcB    = b;
        valid_i = 1'b1;
        lat       = -1;
        stall_cnt = 0;
        #1;
        if (stall_o) stall_cnt++;
        for (int n = 1; n <= 100 && lat < 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                SrcA = ~a;
                SrcB = a ^ b ^ 32'h5a5a_0f0f;
            end
            #1;
            if (md_done) begin
                lat = n;
                check({tag, "_stall_done"}, 64'(stall_o), 64'd0);
                check({tag, "_res"}, 64'(md_result), 64'(exp_res));
                valid_i = 1'b0;
            end else if (stall_o) begin
                stall_cnt++;
            end
        end
        valid_i = 1'b0;
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stalls"}, 64'(stall_cnt), 64'(exp_lat));
        @(negedge clk);
        #1;
        check({tag, "_pulse"}, 64'(md_done), 64'd0);
    endtask

    initial begin
        int first;
        int second;
        bit seen;

        rst_n   = 1'b0;
        ALUOp   = 2'b00;
        RType   = 1'b0;
        Funct7  = 7'd0;
        Funct3  = 3'd0;
        valid_i = 1'b0;
        flush_i = 1'b0;
        SrcA    = '0;
        SrcB    = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_done", 64'(md_done), 64'd0);
        check("rst_result", 64'(md_result), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        rst_n = 1'b1;

        // Opcode decode
        dec("sub",   2'b10, 1'b1, 7'b0100000, 3'b000, 4'b0011, 1'b0);
        dec("add",   2'b10, 1'b1, 7'b0000000, 3'b000, 4'b0010, 1'b0);
        dec("bne",   2'b01, 1'b0, 7'b0000000, 3'b001, 4'b1001, 1'b0);
        dec("br011", 2'b01, 1'b0, 7'b0000000, 3'b011, 4'b1000, 1'b0);
        dec("bge",   2'b01, 1'b0, 7'b0000000, 3'b101, 4'b1011, 1'b0);
        dec("sltu",  2'b10, 1'b1, 7'b0000000, 3'b011, 4'b1101, 1'b0);
        dec("srai",  2'b10, 1'b0, 7'b0100000, 3'b101, 4'b0111, 1'b0);
        dec("srl",   2'b10, 1'b1, 7'b0000000, 3'b101, 4'b0101, 1'b0);
        dec("and",   2'b10, 1'b1, 7'b0000000, 3'b111, 4'b0000, 1'b0);
        dec("lw",    2'b00, 1'b0, 7'b0000000, 3'b010, 4'b0010, 1'b0);
        dec("passb", 2'b11, 1'b0, 7'b0000000, 3'b000, 4'b1110, 1'b0);
        dec("mdiv",  2'b10, 1'b1, 7'b0000001, 3'b100, 4'b0010, 1'b1);
        dec("addi",  2'b10, 1'b0, 7'b0000001, 3'b000, 4'b0010, 1'b0);

        @(negedge clk);

        // Multiply / divide vectors
        run_md("mul",     3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_md("mulhu",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_md("mulhsu",  3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
        run_md("mulh",    3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        run_md("div",     3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_md("rem",     3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_md("divu",    3'b101, 32'd100,        32'd7,         32'd14,        33);
        run_md("remu",    3'b111, 32'd100,        32'd7,         32'd2,         33);
        run_md("rem_pos", 3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33);
        run_md("divu_z",  3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_md("remu_z",  3'b111, 32'd5,          32'd0,         32'd5,         1);
        run_md("div_ovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_md("rem_ovf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
        run_md("div_neg", 3'b100, 32'd6,          32'hFFFF_FFFD, 32'hFFFF_FFFE, 33);

        // Flush in the middle of a divide
        ALUOp   = 2'b10;
        RType   = 1'b1;
        Funct7  = 7'b0000001;
        Funct3  = 3'b101;
        SrcA    = 32'd100;
        SrcB    = 32'd7;
        valid_i = 1'b1;
        for (int n = 1; n <= 10; n++) @(negedge clk);
        #1;
        check("flush_pre_stall", 64'(stall_o), 64'd1);
        flush_i = 1'b1;
        #1;
        check("flush_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        valid_i = 1'b0;
        seen    = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if (md_done) seen = 1'b1;
        end
        check("flush_no_done", 64'(seen), 64'd0);
        check("flush_hold", 64'(md_result), 64'hFFFF_FFFE);
        run_md("mul_after_flush", 3'b000, 32'd3, 32'd5, 32'd15, 33);

        // Back-to-back multiplies with valid held high
        ALUOp   = 2'b10;
        RType   = 1'b1;
        Funct7  = 7'b0000001;
        Funct3  = 3'b000;
        SrcA    = 32'd2;
        SrcB    = 32'd3;
        valid_i = 1'b1;
        first   = -1;
        second  = -1;
        for (int n = 1; n <= 100 && second < 0; n++) begin
            @(negedge clk);
            #1;
            if (md_done) begin
                if (first < 0) begin
                    first = n;
                    check("b2b_res1", 64'(md_result), 64'd6);
                    SrcA = 32'd4;
                    SrcB = 32'd5;
                end else begin
                    second = n;
                    check("b2b_res2", 64'(md_result), 64'd20);
                end
            end
        end
        valid_i = 1'b0;
        check("b2b_first", 64'(first), 64'd33);
        check("b2b_gap", 64'(second - first), 64'd34);
        @(negedge clk);

        // Reset asserted mid-multiply
        Funct3  = 3'b000;
        SrcA    = 32'd9;
        SrcB    = 32'd9;
        valid_i = 1'b1;
        for (int n = 1; n <= 5; n++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_done", 64'(md_done), 64'd0);
        check("rst_mid_result", 64'(md_result), 64'd0);
        valid_i = 1'b0;
        #1;
        check("rst_mid_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if (md_done) seen = 1'b1;
        end
        check("rst_mid_no_done", 64'(seen), 64'd0);
        check("rst_mid_hold", 64'(md_result), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
